// File: rtl/axi_fifo_pkg.sv
// Shared constants for the AXI async FIFO write-domain status logic:
// default address width, depth helper and status-vector bit positions.
package axi_fifo_pkg;

  localparam int AF_ADDRSIZE = 5;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_AEMPTY = 2;
  localparam int ST_AFULL = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_PERR  = 5;
  localparam int ST_W     = 6;

  // Flag state after reset or clear: empty and almost-empty asserted, all else low.
  localparam logic [ST_W-1:0] ST_RESET_VEC = ST_W'((1 << ST_EMPTY) | (1 << ST_AEMPTY));

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

endpackage

// File: rtl/axi_fifo_gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all
// gray bits at and above its position.
module axi_fifo_gray2bin #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/axi_fifo_status.sv
// Write-domain status flags for the AXI async FIFO (empty/full/almost, level,
// high-water, sticky overflow and pointer error). Define GRAY_PTR_EN when the
// synchronised read pointer arrives gray-coded.
module axi_fifo_status
  import axi_fifo_pkg::*;
#(
  parameter int ADDRSIZE = AF_ADDRSIZE
) (
  input  logic                write_clk,
  input  logic                write_rst,
  input  logic                clear,
  input  logic [ADDRSIZE:0]   write_pointer,
  input  logic [ADDRSIZE:0]   read_pointer_sync,
  input  logic                push,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic [ADDRSIZE:0]   aempty_thresh,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [ADDRSIZE:0]   level,
  output logic [ADDRSIZE:0]   high_water,
  output logic                overflow,
  output logic                ptr_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(fifo_depth(ADDRSIZE));

  logic [PW-1:0]   w_rd_bin;
  logic [PW-1:0]   w_diff;
  logic            w_over;
  logic [PW-1:0]   w_level;
  logic [ST_W-1:0] r_status;
  logic [PW-1:0]   r_level;
  logic [PW-1:0]   r_hwm;

`ifdef GRAY_PTR_EN
  axi_fifo_gray2bin #(.W(PW)) u_gray2bin (
    .i_gray (read_pointer_sync),
    .o_bin  (w_rd_bin)
  );
`else
  assign w_rd_bin = read_pointer_sync;
`endif

  // Modular subtract handles pointer wrap; a result above DEPTH means corrupt pointers.
  assign w_diff  = write_pointer - w_rd_bin;
  assign w_over  = (w_diff > DEPTH_P);
  assign w_level = w_over ? DEPTH_P : w_diff;

  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      r_status <= ST_RESET_VEC;
      r_level  <= '0;
      r_hwm    <= '0;
    end else if (clear) begin
      r_status <= ST_RESET_VEC;
      r_level  <= '0;
      r_hwm    <= '0;
    end else begin
      r_status[ST_EMPTY]  <= (w_diff == '0);
      r_status[ST_FULL]   <= (w_diff >= DEPTH_P);
      r_status[ST_AEMPTY] <= (w_diff <= aempty_thresh);
      r_status[ST_AFULL]  <= (w_diff >= afull_thresh);
      r_status[ST_OVF]    <= r_status[ST_OVF] | (push & r_status[ST_FULL]);
      r_status[ST_PERR]   <= r_status[ST_PERR] | w_over;
      r_level             <= w_level;
      r_hwm               <= (w_level > r_hwm) ? w_level : r_hwm;
    end
  end

  assign empty        = r_status[ST_EMPTY];
  assign full         = r_status[ST_FULL];
  assign almost_empty = r_status[ST_AEMPTY];
  assign almost_full  = r_status[ST_AFULL];
  assign overflow     = r_status[ST_OVF];
  assign ptr_err      = r_status[ST_PERR];
  assign level        = r_level;
  assign high_water   = r_hwm;

endmodule

// File: tb/tb_axi_fifo_status.sv
// Scoreboard bench for axi_fifo_status: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares one cycle later.
module tb_axi_fifo_status;

  localparam int DEPTH = 32;

  logic       write_clk = 1'b0;
  logic       write_rst, clear, push;
  logic [5:0] write_pointer, read_pointer_sync, afull_thresh, aempty_thresh;
  logic       empty, full, almost_empty, almost_full, overflow, ptr_err;
  logic [5:0] level, high_water;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       empty, full, aempty, afull, ovf, perr;
    logic [5:0] level, hwm;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int m_hwm;
  bit m_ovf, m_perr, m_full;

  axi_fifo_status #(.ADDRSIZE(5)) dut (
    .write_clk         (write_clk),
    .write_rst         (write_rst),
    .clear             (clear),
    .write_pointer     (write_pointer),
    .read_pointer_sync (read_pointer_sync),
    .push              (push),
    .afull_thresh      (afull_thresh),
    .aempty_thresh     (aempty_thresh),
    .empty             (empty),
    .full              (full),
    .almost_empty      (almost_empty),
    .almost_full       (almost_full),
    .level             (level),
    .high_water        (high_water),
    .overflow          (overflow),
    .ptr_err           (ptr_err)
  );

  always #5 write_clk = ~write_clk;

  function automatic logic [5:0] to_ptr(input int rp);
    logic [5:0] b;
    b = 6'(rp);
`ifdef GRAY_PTR_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Model: fill count is the modular pointer distance in plain integers.
  task automatic step(input string tag, input bit rst, input bit clr, input int wp,
                      input int rp, input bit psh, input int af, input int ae);
    exp_t e;
    int d, lvl;
    @(negedge write_clk);
    wp = wp & 63;
    rp = rp & 63;
    write_rst = rst; clear = clr; push = psh;
    write_pointer = 6'(wp);
    read_pointer_sync = to_ptr(rp);
    afull_thresh = 6'(af); aempty_thresh = 6'(ae);
    e = '0;
    if (!rst || clr) begin
      m_hwm = 0; m_ovf = 0; m_perr = 0; m_full = 0;
      e.empty = 1'b1; e.aempty = 1'b1;
    end else begin
      d = (wp - rp + 64) % 64;
      lvl = (d > DEPTH) ? DEPTH : d;
      if (psh && m_full) m_ovf = 1;
      if (d > DEPTH) m_perr = 1;
      m_full = (d >= DEPTH);
      if (lvl > m_hwm) m_hwm = lvl;
      e.empty  = (d == 0);
      e.full   = m_full;
      e.aempty = (d <= ae);
      e.afull  = (d >= af);
      e.ovf    = m_ovf;
      e.perr   = m_perr;
      e.level  = 6'(lvl);
      e.hwm    = 6'(m_hwm);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    exp_t  e, a;
    string t;
    forever begin
      @(posedge write_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {empty, full, almost_empty, almost_full, overflow, ptr_err, level, high_water};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s: got e/f/ae/af/ovf/perr=%b lvl=%0d hwm=%0d, want %b lvl=%0d hwm=%0d",
                   t, a[17:12], a.level, a.hwm, e[17:12], e.level, e.hwm);
        end
      end
    end
  end

  initial begin : stimulus
    int rp, d, wp;
    write_rst = 0; clear = 0; push = 0;
    write_pointer = '0; read_pointer_sync = '0;
    afull_thresh = 6'd28; aempty_thresh = 6'd4;

    step("reset", 0, 0, 0, 0, 0, 28, 4);
    step("reset", 0, 0, 0, 0, 0, 28, 4);
    step("reset_release", 1, 0, 0, 0, 0, 28, 4);

    for (int i = 0; i <= 32; i++) step("fill", 1, 0, i, 0, 0, 28, 4);
    step("fill_hold", 1, 0, 32, 0, 0, 28, 4);

    step("ovf_push", 1, 0, 32, 0, 1, 28, 4);
    step("ovf_sticky", 1, 0, 32, 0, 0, 28, 4);
    step("ovf_sticky", 1, 0, 0, 0, 0, 28, 4);
    step("clear", 1, 1, 32, 0, 1, 28, 4);
    step("post_clear", 1, 0, 0, 0, 1, 28, 4);

    step("wrap_full", 1, 0, 'h21, 'h01, 0, 28, 4);
    step("wrap_full", 1, 0, 'h21, 'h01, 1, 28, 4);
    step("wrap_empty", 1, 0, 'h21, 'h21, 0, 28, 4);
    step("wrap_mod", 1, 0, 'h02, 'h3e, 0, 28, 4);

    step("ptr_err", 1, 0, 40, 0, 0, 28, 4);
    step("ptr_err_sticky", 1, 0, 5, 5, 0, 28, 4);
    step("ptr_err_sticky", 1, 0, 5, 5, 0, 28, 4);
    step("clear", 1, 1, 5, 5, 0, 28, 4);

    step("gray_empty", 1, 0, 4, 4, 0, 28, 4);
    step("gray_level", 1, 0, 10, 4, 0, 28, 4);
    step("afull_zero", 1, 0, 4, 4, 0, 0, 0);
    step("aempty_edge", 1, 0, 8, 4, 0, 28, 4);
    step("aempty_edge", 1, 0, 9, 4, 0, 28, 4);
    step("mid_fill", 1, 0, 24, 4, 0, 28, 4);

    // Async reset asserted between clock edges: outputs must drop at once.
    step("reset_mid", 0, 0, 24, 4, 0, 28, 4);
    #1;
    vectors++;
    if ({empty, full, almost_empty, almost_full, overflow, ptr_err, level, high_water} !==
        {6'b101000, 6'd0, 6'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got e/f/ae/af/ovf/perr=%b lvl=%0d hwm=%0d, want 101000 lvl=0 hwm=0",
               {empty, full, almost_empty, almost_full, overflow, ptr_err}, level, high_water);
    end
    step("reset_release", 1, 0, 0, 0, 0, 28, 4);

    for (int n = 0; n < 600; n++) begin
      rp = int'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) d = int'($urandom_range(33, 63));
      else d = int'($urandom_range(0, 32));
      wp = rp + d;
      step("random", ($urandom_range(0, 79) != 0), ($urandom_range(0, 23) == 0), wp, rp,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge write_clk);
    #3;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
